mem_trace_buffer: RTL and testbench

MEM_TRACE_BUFFER -- requirements
Module: mem_trace_buffer

---
 rtl/riscv_trace_pkg.sv | 25 ++
 rtl/trace_fifo.sv | 68 ++++++
 rtl/mem_trace_buffer.sv | 98 +++++++++
 tb/tb_mem_trace_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_trace_pkg
// Purpose  : Shared constants for the memory-store trace buffer: record
//            layout width and overflow-policy (WRAP) encodings.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_trace_pkg;

  // WRAP parameter encodings: what happens to a new event when the buffer is full
  localparam int WRAP_DROP      = 0;  // discard the new event
  localparam int WRAP_OVERWRITE = 1;  // evict the oldest entry to make room

  // Default field widths and the resulting record width {ts, addr, data}
  localparam int TRACE_DW    = 32;
  localparam int TRACE_TSW   = 16;
  localparam int TRACE_REC_W = TRACE_TSW + 2 * TRACE_DW;

  // Record width for arbitrary field widths
  function automatic int rec_width(input int dw, input int tsw);
    return tsw + 2 * dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo
// Purpose  : Show-ahead circular FIFO holding trace records. Head data is
//            presented combinationally and forced to zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 80
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    occ;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head is leaving the same cycle;
  // in that case wr_ptr == rd_ptr and the new record lands in the freed slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign full  = (occ == CW'(DEPTH));
  assign empty = (occ == '0);
  assign count = occ;
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage array: written on accepted pushes, never reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; occupancy tracks push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_trace_buffer
// Purpose  : Captures M-stage stores whose address falls in an inclusive
//            window, timestamps them, and queues them for a consumer. Full
//            behaviour is either drop-new or overwrite-oldest (WRAP).
// Revision : 1.0 - initial release
// ============================================================================
module mem_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int TSW   = 16,
  parameter int WRAP  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cap_en,
  input  logic                   memrw_i,
  input  logic [DW-1:0]          addr_i,
  input  logic [DW-1:0]          wdata_i,
  input  logic [DW-1:0]          filt_lo,
  input  logic [DW-1:0]          filt_hi,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [TSW-1:0]         rd_ts,
  output logic [DW-1:0]          rd_addr,
  output logic [DW-1:0]          rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            ovf_cnt,
  output logic                   full,
  output logic                   empty
);

  import riscv_trace_pkg::*;

  localparam int RW        = rec_width(DW, TSW);
  localparam bit OVERWRITE = (WRAP == WRAP_OVERWRITE);

  logic [TSW-1:0] ts;
  logic           in_window;
  logic           cap_evt;
  logic           pop_req;
  logic           lost;
  logic           fifo_push;
  logic           fifo_pop;
  logic [RW-1:0]  head;

  // An inverted window (lo > hi) never matches
  assign in_window = (filt_lo <= filt_hi) && (addr_i >= filt_lo) && (addr_i <= filt_hi);
  assign cap_evt   = cap_en && memrw_i && in_window;
  assign pop_req   = rd_ready && !empty;

  // An event is "lost" when it arrives at a full buffer with no pop to make room;
  // in overwrite mode it still gets stored by forcing the oldest entry out.
  assign lost      = cap_evt && full && !pop_req;
  assign fifo_push = cap_evt && (!full || pop_req || OVERWRITE);
  assign fifo_pop  = pop_req || (lost && OVERWRITE);

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({ts, addr_i, wdata_i}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign rd_valid = !empty;
  assign rd_ts    = head[RW-1 -: TSW];
  assign rd_addr  = head[2*DW-1 -: DW];
  assign rd_data  = head[DW-1:0];

  // Free-running timestamp, advancing only while capture is enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (cap_en) begin
      ts <= ts + TSW'(1);
    end
  end

  // Saturating count of dropped or overwritten events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (lost && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_trace_buffer
// Purpose  : Bench for mem_trace_buffer: two DEPTH=4 instances (drop-new and
//            overwrite-oldest) share capture stimulus; a queue scoreboard
//            plus directed constant checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_trace_buffer;

  typedef struct packed {
    logic [15:0] ts;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic        cap_en;
  logic        memrw_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] filt_lo;
  logic [31:0] filt_hi;
  logic        rd_ready [2];
  logic        rd_valid [2];
  logic [15:0] rd_ts    [2];
  logic [31:0] rd_addr  [2];
  logic [31:0] rd_data  [2];
  logic [2:0]  count    [2];
  logic [15:0] ovf_cnt  [2];
  logic        full     [2];
  logic        empty    [2];

  int          total = 0;
  int          bad   = 0;

  entry_t      q0[$];
  entry_t      q1[$];
  logic [15:0] ts_m;
  logic [15:0] ovf_m [2];

  mem_trace_buffer #(.DEPTH(4), .DW(32), .TSW(16), .WRAP(0)) dut_drop (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .memrw_i(memrw_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .filt_lo(filt_lo), .filt_hi(filt_hi),
    .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_ts(rd_ts[0]),
    .rd_addr(rd_addr[0]), .rd_data(rd_data[0]), .count(count[0]),
    .ovf_cnt(ovf_cnt[0]), .full(full[0]), .empty(empty[0])
  );

  mem_trace_buffer #(.DEPTH(4), .DW(32), .TSW(16), .WRAP(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .memrw_i(memrw_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .filt_lo(filt_lo), .filt_hi(filt_hi),
    .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_ts(rd_ts[1]),
    .rd_addr(rd_addr[1]), .rd_data(rd_data[1]), .count(count[1]),
    .ovf_cnt(ovf_cnt[1]), .full(full[1]), .empty(empty[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare flags, counters and (when empty) zeroed head against the model
  task automatic check_state(input int m);
    int sz;
    sz = (m == 0) ? q0.size() : q1.size();
    chk($sformatf("count%0d", m), 64'(count[m]), 64'(sz));
    chk($sformatf("empty%0d", m), 64'(empty[m]), 64'(sz == 0));
    chk($sformatf("full%0d", m), 64'(full[m]), 64'(sz == 4));
    chk($sformatf("valid%0d", m), 64'(rd_valid[m]), 64'(sz != 0));
    chk($sformatf("ovf%0d", m), 64'(ovf_cnt[m]), 64'(ovf_m[m]));
    if (sz == 0) begin
      chk($sformatf("zero_head%0d", m), {rd_ts[m], rd_addr[m], rd_data[m]}, 64'h0);
    end
  endtask

  // Scoreboard step for one instance: check and retire head on pop, then apply capture
  task automatic sb_cycle(input int m, input bit ev, input entry_t e, input bit rdy, input bit wrap);
    int     sz;
    entry_t h;
    sz = (m == 0) ? q0.size() : q1.size();
    if (rdy && sz > 0) begin
      h = (m == 0) ? q0[0] : q1[0];
      chk($sformatf("pop_ts%0d", m), 64'(rd_ts[m]), 64'(h.ts));
      chk($sformatf("pop_addr%0d", m), 64'(rd_addr[m]), 64'(h.addr));
      chk($sformatf("pop_data%0d", m), 64'(rd_data[m]), 64'(h.data));
      if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      sz--;
    end
    if (ev) begin
      if (sz < 4) begin
        if (m == 0) q0.push_back(e); else q1.push_back(e);
      end else begin
        if (wrap) begin
          if (m == 0) begin void'(q0.pop_front()); q0.push_back(e); end
          else        begin void'(q1.pop_front()); q1.push_back(e); end
        end
        if (ovf_m[m] != 16'hFFFF) ovf_m[m] = ovf_m[m] + 16'd1;
      end
    end
  endtask

  // Drive one cycle of stimulus, update the model, then check after the edge
  task automatic tick(input bit cap, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input bit r0, input bit r1);
    bit     ev;
    entry_t e;
    cap_en      = cap;
    memrw_i     = wr;
    addr_i      = a;
    wdata_i     = d;
    rd_ready[0] = r0;
    rd_ready[1] = r1;
    ev = cap && wr && (filt_lo <= a) && (a <= filt_hi);
    e  = '{ts: ts_m, addr: a, data: d};
    sb_cycle(0, ev, e, r0, 1'b0);
    sb_cycle(1, ev, e, r1, 1'b1);
    if (cap) ts_m = ts_m + 16'd1;
    @(posedge clk);
    #1;
    check_state(0);
    check_state(1);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    ts_m     = '0;
    ovf_m[0] = '0;
    ovf_m[1] = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    cap_en      = 1'b0;
    memrw_i     = 1'b0;
    addr_i      = '0;
    wdata_i     = '0;
    filt_lo     = 32'h0;
    filt_hi     = 32'hFFFF_FFFF;
    rd_ready[0] = 1'b0;
    rd_ready[1] = 1'b0;
    model_reset();

    // Reset state
    #1;
    check_state(0);
    check_state(1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Two stores at ts 3 and ts 5, popped in order
    tick(1, 0, 32'h0, 32'h0, 0, 0);
    tick(1, 0, 32'h0, 32'h0, 0, 0);
    tick(1, 0, 32'h0, 32'h0, 0, 0);
    tick(1, 1, 32'h10, 32'hAA, 0, 0);
    tick(1, 0, 32'h0, 32'h0, 0, 0);
    tick(1, 1, 32'h14, 32'hBB, 0, 0);
    chk("first_head", {rd_ts[0], rd_addr[0], rd_data[0]}, {16'd3, 32'h10, 32'hAA});
    tick(1, 0, 32'h0, 32'h0, 1, 1);
    chk("second_head", {rd_ts[0], rd_addr[0], rd_data[0]}, {16'd5, 32'h14, 32'hBB});
    tick(1, 0, 32'h0, 32'h0, 1, 1);
    chk("drained_empty", 64'(empty[0]), 64'd1);

    // Address window 0x100..0x1FF: only the two inner stores match
    filt_lo = 32'h100;
    filt_hi = 32'h1FF;
    tick(1, 1, 32'h0FC, 32'h1, 0, 0);
    tick(1, 1, 32'h100, 32'h2, 0, 0);
    tick(1, 1, 32'h1FF, 32'h3, 0, 0);
    tick(1, 1, 32'h200, 32'h4, 0, 0);
    chk("win_count", 64'(count[0]), 64'd2);
    chk("win_first", 64'(rd_addr[0]), 64'h100);
    tick(1, 0, 32'h0, 32'h0, 1, 1);
    chk("win_second", 64'(rd_addr[0]), 64'h1FF);
    tick(1, 0, 32'h0, 32'h0, 1, 1);

    // Inverted window never matches
    filt_lo = 32'h200;
    filt_hi = 32'h100;
    tick(1, 1, 32'h150, 32'h5, 0, 0);
    tick(1, 1, 32'h200, 32'h6, 0, 0);
    chk("inv_win_empty", 64'(count[0]), 64'd0);

    // Six stores into a 4-deep buffer with no consumer
    filt_lo = 32'h0;
    filt_hi = 32'hFFFF_FFFF;
    for (int i = 1; i <= 6; i++) tick(1, 1, 32'h40 + 32'(i), 32'(i), 0, 0);
    chk("drop_full", 64'(full[0]), 64'd1);
    chk("drop_ovf", 64'(ovf_cnt[0]), 64'd2);
    chk("wrap_full", 64'(full[1]), 64'd1);
    chk("wrap_ovf", 64'(ovf_cnt[1]), 64'd2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drop_order%0d", i), 64'(rd_data[0]), 64'(i + 1));
      chk($sformatf("wrap_order%0d", i), 64'(rd_data[1]), 64'(i + 3));
      tick(1, 0, 32'h0, 32'h0, 1, 1);
    end

    // Store into a full buffer while the consumer pops
    for (int i = 1; i <= 4; i++) tick(1, 1, 32'h60, 32'h20 + 32'(i), 0, 0);
    tick(1, 1, 32'h64, 32'h25, 1, 1);
    chk("fullpop_count", 64'(count[0]), 64'd4);
    chk("fullpop_ovf", 64'(ovf_cnt[0]), 64'd2);
    chk("fullpop_ovf_w", 64'(ovf_cnt[1]), 64'd2);
    for (int i = 0; i < 3; i++) tick(1, 0, 32'h0, 32'h0, 1, 1);
    chk("fullpop_last", 64'(rd_data[0]), 64'h25);
    chk("fullpop_last_w", 64'(rd_data[1]), 64'h25);
    tick(1, 0, 32'h0, 32'h0, 1, 1);

    // Mid-operation reset with three entries stored
    for (int i = 1; i <= 3; i++) tick(1, 1, 32'h70, 32'(i), 0, 0);
    chk("pre_rst_count", 64'(count[0]), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_empty", 64'(empty[0]), 64'd1);
    chk("rst_count", 64'(count[0]), 64'd0);
    chk("rst_ovf", 64'(ovf_cnt[0]), 64'd0);
    check_state(0);
    check_state(1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick(1, 1, 32'h80, 32'h99, 0, 0);
    chk("post_rst_ts", 64'(rd_ts[0]), 64'd0);
    chk("post_rst_ts_w", 64'(rd_ts[1]), 64'd0);
    chk("post_rst_addr", 64'(rd_addr[0]), 64'h80);
    tick(1, 0, 32'h0, 32'h0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
